mips_multicycle_controller: RTL and testbench

Multicycle control FSM for the MIPS core's shared-memory datapath. One memory port serves both instruction fetch and data access; this block sequences each instruction over 3–5 cycles. It drives:

- the instruction-register, PC, register-file and memory write enables;
- the datapath mux selects;
- the ALU control code.

It decodes opcode and funct from the held instruction register, and takes the ALU zero flag for branches.

---
 rtl/mips_multicycle_controller_if.sv | 46 ++++
 rtl/mips_multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_controller_if
// Description : Control bundle between the multicycle controller and the
//               datapath: decoded instruction fields and ALU zero flag in,
//               enables / mux selects / ALU code out.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] state;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal;

    // Controller side: consumes instruction fields, drives control
    modport master (
        input  op, funct, zero,
        output state, irwrite, pcwrite, branch, pcen, iord, memwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
               alucontrol, instr_done, illegal
    );

    // Datapath side: supplies instruction fields, obeys control
    modport slave (
        output op, funct, zero,
        input  state, irwrite, pcwrite, branch, pcen, iord, memwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
               alucontrol, instr_done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_controller
// Description : Moore control FSM for a shared-memory multicycle MIPS
//               datapath. Sequences lw/sw/R-type/beq/addi/j over 3-5 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_controller (
    input  wire logic                        clk,
    input  wire logic                        reset,
    mips_multicycle_controller_if.master     bus
);

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic       funct_bad_q, funct_bad_d;

    logic [2:0] w_funct_alu;
    logic       w_funct_ok;

    logic       w_irwrite, w_pcwrite, w_branch, w_iord, w_memwrite;
    logic       w_memtoreg, w_regdst, w_regwrite, w_alusrca;
    logic       w_instr_done, w_illegal;
    logic [1:0] w_alusrcb, w_pcsrc;
    logic [2:0] w_alucontrol;

    // State and unsupported-funct flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            funct_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct_bad_q <= funct_bad_d;
        end
    end

    // R-type funct decode; unsupported functs fall back to add
    always_comb begin
        w_funct_alu = 3'b010;
        w_funct_ok  = 1'b1;
        case (bus.funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Flag is captured in DECODE and held through ALUWB to mute writeback
    always_comb begin
        funct_bad_d = funct_bad_q;
        if (state_q == S_DECODE)
            funct_bad_d = (bus.op == C_OP_RTYPE) && !w_funct_ok;
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d      = S_FETCH;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_alucontrol = 3'b010;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (bus.op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE: begin
                        state_d   = S_EXECUTE;
                        w_illegal = !w_funct_ok;
                    end
                    C_OP_BEQ:  state_d = S_BRANCH;
                    C_OP_ADDI: state_d = S_ADDIEXEC;
                    C_OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                state_d   = (bus.op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_memtoreg   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca    = 1'b1;
                w_alucontrol = w_funct_alu;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = !funct_bad_q;
                w_regdst     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_alucontrol = 3'b110;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                // Unreachable codes: everything quiet, recover to FETCH
                w_alucontrol = 3'b000;
                state_d      = S_FETCH;
            end
        endcase
    end

    // Enables are masked by reset so nothing writes while it is held;
    // selects already show FETCH values because the state is forced to 0.
    assign bus.state      = state_q;
    assign bus.irwrite    = w_irwrite    & ~reset;
    assign bus.pcwrite    = w_pcwrite    & ~reset;
    assign bus.branch     = w_branch     & ~reset;
    assign bus.pcen       = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
    assign bus.memwrite   = w_memwrite   & ~reset;
    assign bus.regwrite   = w_regwrite   & ~reset;
    assign bus.instr_done = w_instr_done & ~reset;
    assign bus.illegal    = w_illegal    & ~reset;
    assign bus.iord       = w_iord;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regdst     = w_regdst;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.alucontrol = w_alucontrol;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_controller
// Description : Directed self-checking bench for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_multicycle_controller_if bus ();

    mips_multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] enables();
        return {bus.irwrite, bus.pcwrite, bus.branch, bus.pcen,
                bus.memwrite, bus.regwrite, bus.instr_done, bus.illegal};
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        bus.op    = 6'b111111;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.state !== 4'd0) begin
                n_fail++; $display("FAIL reset_state cyc%0d: got %0d want 0", i, bus.state);
            end
            n_checks++;
            if (enables() !== 8'h00) begin
                n_fail++; $display("FAIL reset_enables cyc%0d: got %b want 00000000", i, enables());
            end
            n_checks++;
            if (bus.alusrcb !== 2'b01) begin
                n_fail++; $display("FAIL reset_alusrcb cyc%0d: got %b want 01", i, bus.alusrcb);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.irwrite, bus.pcwrite} !== 2'b11) begin
            n_fail++; $display("FAIL post_reset_fetch: got %b want 11", {bus.irwrite, bus.pcwrite});
        end
        step();
        n_checks++;
        if (bus.state !== 4'd1) begin
            n_fail++; $display("FAIL post_reset_decode: got %0d want 1", bus.state);
        end
        // op 111111 is unsupported: illegal in DECODE, straight back to FETCH
        n_checks++;
        if (bus.illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_op_flag: got %b want 1", bus.illegal);
        end
        step();
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL illegal_op_next: got %0d want 0", bus.state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        bus.op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.state !== exp_s[i]) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, exp_s[i]);
            end
            n_checks++;
            if (bus.instr_done !== (i == 4)) begin
                n_fail++; $display("FAIL lw_done[%0d]: got %b want %b", i, bus.instr_done, (i == 4));
            end
            if (i == 3) begin
                n_checks++;
                if (bus.iord !== 1'b1) begin
                    n_fail++; $display("FAIL lw_iord: got %b want 1", bus.iord);
                end
            end
            if (i == 4) begin
                n_checks++;
                if ({bus.regwrite, bus.memtoreg, bus.regdst} !== 3'b110) begin
                    n_fail++; $display("FAIL lw_wb: got %b want 110", {bus.regwrite, bus.memtoreg, bus.regdst});
                end
            end
            step();
        end
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL lw_end: got %0d want 0", bus.state);
        end
    endtask

    task automatic test_sw_rtype();
        logic [3:0] sw_s [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [3:0] r_s  [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        bus.op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.state !== sw_s[i]) begin
                n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state, sw_s[i]);
            end
            n_checks++;
            if (bus.memwrite !== (i == 3)) begin
                n_fail++; $display("FAIL sw_memwrite[%0d]: got %b want %b", i, bus.memwrite, (i == 3));
            end
            step();
        end
        bus.op    = 6'b000000;
        bus.funct = 6'b101010;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.state !== r_s[i]) begin
                n_fail++; $display("FAIL r_state[%0d]: got %0d want %0d", i, bus.state, r_s[i]);
            end
            if (i == 1) begin
                n_checks++;
                if (bus.illegal !== 1'b0) begin
                    n_fail++; $display("FAIL r_illegal: got %b want 0", bus.illegal);
                end
            end
            if (i == 2) begin
                n_checks++;
                if ({bus.alucontrol, bus.alusrca, bus.alusrcb} !== 6'b111_1_00) begin
                    n_fail++; $display("FAIL r_exec: got %b want 111100", {bus.alucontrol, bus.alusrca, bus.alusrcb});
                end
            end
            if (i == 3) begin
                n_checks++;
                if ({bus.regdst, bus.regwrite, bus.instr_done} !== 3'b111) begin
                    n_fail++; $display("FAIL r_wb: got %b want 111", {bus.regdst, bus.regwrite, bus.instr_done});
                end
            end
            step();
        end
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL r_end: got %0d want 0", bus.state);
        end
    endtask

    task automatic test_beq();
        bus.op = 6'b000100;
        for (int pass = 0; pass < 2; pass++) begin
            bus.zero = (pass == 0);
            step();
            step();
            n_checks++;
            if (bus.state !== 4'd8) begin
                n_fail++; $display("FAIL beq_state p%0d: got %0d want 8", pass, bus.state);
            end
            n_checks++;
            if (bus.pcen !== (pass == 0)) begin
                n_fail++; $display("FAIL beq_pcen p%0d: got %b want %b", pass, bus.pcen, (pass == 0));
            end
            n_checks++;
            if ({bus.pcsrc, bus.alucontrol, bus.branch, bus.pcwrite} !== 7'b01_110_1_0) begin
                n_fail++; $display("FAIL beq_ctl p%0d: got %b want 0111010", pass,
                                   {bus.pcsrc, bus.alucontrol, bus.branch, bus.pcwrite});
            end
            if (pass == 0) begin
                // zero falling inside BRANCH must show on pcen in the same cycle
                bus.zero = 1'b0;
                #1;
                n_checks++;
                if (bus.pcen !== 1'b0) begin
                    n_fail++; $display("FAIL beq_pcen_comb: got %b want 0", bus.pcen);
                end
            end
            step();
            n_checks++;
            if (bus.state !== 4'd0) begin
                n_fail++; $display("FAIL beq_next p%0d: got %0d want 0", pass, bus.state);
            end
        end
    endtask

    task automatic test_j_addi_illegal();
        logic [3:0] a_s [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        bus.op = 6'b000010;
        step();
        step();
        n_checks++;
        if (bus.state !== 4'd11) begin
            n_fail++; $display("FAIL j_state: got %0d want 11", bus.state);
        end
        n_checks++;
        if ({bus.pcwrite, bus.pcsrc, bus.pcen, bus.instr_done} !== 5'b1_10_1_1) begin
            n_fail++; $display("FAIL j_ctl: got %b want 11011", {bus.pcwrite, bus.pcsrc, bus.pcen, bus.instr_done});
        end
        step();
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL j_next: got %0d want 0", bus.state);
        end

        bus.op = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.state !== a_s[i]) begin
                n_fail++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, bus.state, a_s[i]);
            end
            if (i == 2) begin
                n_checks++;
                if ({bus.alusrca, bus.alusrcb} !== 3'b110) begin
                    n_fail++; $display("FAIL addi_exec: got %b want 110", {bus.alusrca, bus.alusrcb});
                end
            end
            if (i == 3) begin
                n_checks++;
                if ({bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b100) begin
                    n_fail++; $display("FAIL addi_wb: got %b want 100", {bus.regwrite, bus.regdst, bus.memtoreg});
                end
            end
            step();
        end

        // R-type with unsupported funct runs as a nop
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        step();
        n_checks++;
        if ({bus.state, bus.illegal} !== {4'd1, 1'b1}) begin
            n_fail++; $display("FAIL badfunct_decode: got st=%0d ill=%b want st=1 ill=1", bus.state, bus.illegal);
        end
        step();
        n_checks++;
        if ({bus.state, bus.alucontrol} !== {4'd6, 3'b010}) begin
            n_fail++; $display("FAIL badfunct_exec: got st=%0d alu=%b want st=6 alu=010", bus.state, bus.alucontrol);
        end
        step();
        n_checks++;
        if ({bus.state, bus.regwrite, bus.instr_done} !== {4'd7, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL badfunct_wb: got st=%0d rw=%b done=%b want st=7 rw=0 done=1",
                               bus.state, bus.regwrite, bus.instr_done);
        end
        step();
        // A following good R-type must not inherit the nop flag
        bus.funct = 6'b100000;
        step();
        step();
        step();
        n_checks++;
        if ({bus.state, bus.regwrite} !== {4'd7, 1'b1}) begin
            n_fail++; $display("FAIL goodfunct_after_bad: got st=%0d rw=%b want st=7 rw=1", bus.state, bus.regwrite);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.op = 6'b100011;
        step();
        step();
        step();
        n_checks++;
        if (bus.state !== 4'd3) begin
            n_fail++; $display("FAIL mid_pre_state: got %0d want 3", bus.state);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL mid_async_state: got %0d want 0", bus.state);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (enables() !== 8'h00) begin
                n_fail++; $display("FAIL mid_enables cyc%0d: got %b want 00000000", i, enables());
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.state, bus.irwrite, bus.regwrite} !== {4'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL mid_restart: got st=%0d ir=%b rw=%b want st=0 ir=1 rw=0",
                               bus.state, bus.irwrite, bus.regwrite);
        end
        step();
        n_checks++;
        if (bus.state !== 4'd1) begin
            n_fail++; $display("FAIL mid_restart_decode: got %0d want 1", bus.state);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lw();
        test_sw_rtype();
        test_beq();
        test_j_addi_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
